stencil_test_ctrl: RTL and testbench
====================================

// Module: stencil_test_ctrl
// PURPOSE
//  Per-fragment stencil test sequencer between the alpha test and the depth test.
//  Accepts one fragment at a time and reads the 8-bit stencil word at (x,y) from the
//  shared Z/stencil memory. Evaluates the compare function against a reference,
//  writes back the pass/fail stencil-op result, then emits the pass flag downstream.
//  Strictly one fragment in flight, so read-after-write ordering is guaranteed.
// PARAMETERS
//  X_RES   1280                       horizontal resolution, pixels
//  Y_RES   720                        vertical resolution, pixels
//  ID_W    8                          fragment tag width, passed through unchanged
//  XW      $clog2(X_RES)              x coordinate width (derived)
//  YW      $clog2(Y_RES)              y coordinate width (derived)
//  AW      $clog2(X_RES*Y_RES)        memory word address width (derived)
// PORTS
//  clk_i         in   1     clock; single clock domain
//  rst_ni        in   1     reset, asynchronous assert, active-low
//  frag_valid_i  in   1     fragment request valid
//  frag_ready_o  out  1     controller can accept a fragment
//  frag_x_i      in   XW    fragment x
//  frag_y_i      in   YW    fragment y
//  frag_id_i     in   ID_W  fragment tag
//  ref_val_i     in   8     stencil reference value
//  func_i        in   3     compare: 0 NEVER,1 LESS,2 LEQUAL,3 GREATER,4 GEQUAL,5 EQUAL,6 NOTEQUAL,7 ALWAYS
//  read_mask_i   in   8     mask applied to ref and stored value before compare
//  write_mask_i  in   8     bits of the stored value that may change
//  fail_op_i     in   3     op on fail: 0 KEEP,1 ZERO,2 REPLACE,3 INCR,4 DECR,5 INVERT,6 INCR_WRAP,7 DECR_WRAP
//  pass_op_i     in   3     op on pass, same encoding as fail_op_i
//  mem_req_o     out  1     memory request; held until granted
//  mem_gnt_i     in   1     request accepted this cycle
//  mem_we_o      out  1     1 = write, 0 = read
//  mem_addr_o    out  AW    word address = y*X_RES + x
//  mem_wdata_o   out  8     write data
//  mem_rvalid_i  in   1     read data valid, one pulse per granted read
//  mem_rdata_i   in   8     read data
//  out_valid_o   out  1     test result valid
//  out_ready_i   in   1     downstream accepts the result
//  out_id_o      out  ID_W  tag of the fragment being reported
//  out_pass_o    out  1     1 = stencil pass, 0 = cull
//  busy_o        out  1     high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs read 0 except frag_ready_o=1. The reset takes effect
//    immediately, mid-operation included. An in-flight request is dropped, no write is issued,
//    and no result is emitted. A late mem_rvalid_i after reset is ignored.
//  - Accept: frag_valid_i & frag_ready_o. frag_ready_o = (state==IDLE).
//    x, y, id and all configuration inputs are latched at accept. Later changes to them
//    do not affect the fragment in flight.
//  - FSM states: IDLE, RD_REQ, RD_WAIT, EVAL, WR_REQ, RESP.
//    IDLE->RD_REQ on accept. If x>=X_RES or y>=Y_RES: IDLE->RESP, no memory access, pass=0.
//    RD_REQ: mem_req_o=1, mem_we_o=0. ->RD_WAIT on mem_gnt_i.
//      mem_rvalid_i is also taken in the grant cycle if asserted there.
//    RD_WAIT: capture mem_rdata_i on mem_rvalid_i, ->EVAL. mem_rvalid_i is ignored in every other state.
//    EVAL (1 cycle): compute pass and new value. ->WR_REQ if new value != stored value, else ->RESP.
//    WR_REQ: mem_req_o=1, mem_we_o=1, same address, mem_wdata_o=new value. ->RESP on mem_gnt_i.
//      Writes are posted; no write response is expected.
//    RESP: out_valid_o=1, held with id and pass stable until out_ready_i. ->IDLE on handshake.
//  - Compare: (ref & rmask) FUNC (stored & rmask), unsigned 8-bit. LESS passes when masked ref < masked stored.
//  - Ops: ZERO=0x00. REPLACE=ref. INCR saturates at 0xFF. DECR saturates at 0x00.
//    INVERT=~stored. INCR_WRAP: 0xFF->0x00. DECR_WRAP: 0x00->0xFF.
//    new = (stored & ~wmask) | (op_result & wmask).
//  - Latency, zero-wait memory with rvalid one cycle after grant, accept at cycle 0:
//    RD_REQ c1, RD_WAIT c2, EVAL c3, then RESP c4 (no write) or WR_REQ c4 and RESP c5.
//  - Stalls: mem_gnt_i low or out_ready_i low holds the current state and all outputs.
//    out_valid_o is never withdrawn before the handshake.
// TESTING
//  1. Stored 0x05, ref 0x05, EQUAL, pass_op REPLACE -> pass=1, no write issued, result at cycle 4.
//  2. Stored 0x03, ref 0x07, LESS, fail_op INCR, wmask 0xFF -> pass=0, write 0x04 at the same address.
//  3. Stored 0xFF, INCR vs INCR_WRAP; stored 0x00, DECR vs DECR_WRAP
//     -> writes: none (0xFF unchanged), 0x00, none (0x00 unchanged), 0xFF.
//  4. Stored 0xA5, INVERT, wmask 0x0F, ALWAYS -> pass=1, write 0xAA.
//  5. x=1280, y=0 -> no mem_req_o, pass=0, response in cycle 1.
//     Then mem_gnt_i held low 5 cycles and out_ready_i held low 3 cycles -> state and outputs held.
//  6. rst_ni asserted in WR_REQ -> mem_req_o=0 immediately, no result. A late rvalid is ignored.
//     The next fragment is accepted normally.

Source files
------------

// File: rtl/stencil_test_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module: stencil_test_ctrl
//
// Per-fragment stencil test sequencer sitting between the alpha test and the
// depth test. One fragment is accepted at a time. Its stencil word is read
// from the shared Z/stencil memory, compared against the reference value, and
// updated with the pass/fail stencil op when the value changes. The pass flag
// is then reported downstream. Because only one fragment is ever in flight,
// a later read can never overtake an earlier write to the same pixel.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   frag_valid_i/ready_o   fragment request handshake
//   frag_x_i, frag_y_i     pixel coordinates
//   frag_id_i              fragment tag, returned unchanged on out_id_o
//   ref_val_i, func_i      stencil reference and compare function
//   read_mask_i            mask applied to both operands before the compare
//   write_mask_i           stored bits that the op is allowed to change
//   fail_op_i, pass_op_i   stencil op applied on fail / pass
//   mem_req_o/gnt_i        memory request, held until granted
//   mem_we_o               1 = write, 0 = read
//   mem_addr_o             word address y*X_RES + x
//   mem_wdata_o            write data
//   mem_rvalid_i/rdata_i   read data return, one pulse per granted read
//   out_valid_o/ready_i    result handshake
//   out_id_o, out_pass_o   tag and pass flag of the reported fragment
//   busy_o                 high whenever the controller is not idle
// ---------------------------------------------------------------------------
module stencil_test_ctrl #(
   parameter int X_RES = 1280,
   parameter int Y_RES = 720,
   parameter int ID_W  = 8,
   parameter int XW    = $clog2(X_RES),
   parameter int YW    = $clog2(Y_RES),
   parameter int AW    = $clog2(X_RES * Y_RES)
) (
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            frag_valid_i,
   output logic            frag_ready_o,
   input  logic [XW-1:0]   frag_x_i,
   input  logic [YW-1:0]   frag_y_i,
   input  logic [ID_W-1:0] frag_id_i,
   input  logic [7:0]      ref_val_i,
   input  logic [2:0]      func_i,
   input  logic [7:0]      read_mask_i,
   input  logic [7:0]      write_mask_i,
   input  logic [2:0]      fail_op_i,
   input  logic [2:0]      pass_op_i,

   output logic            mem_req_o,
   input  logic            mem_gnt_i,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [7:0]      mem_wdata_o,
   input  logic            mem_rvalid_i,
   input  logic [7:0]      mem_rdata_i,

   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [ID_W-1:0] out_id_o,
   output logic            out_pass_o,
   output logic            busy_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_EVAL    = 3'd3,
      S_WR_REQ  = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   // Compare function encoding
   localparam logic [2:0] F_NEVER    = 3'd0;
   localparam logic [2:0] F_LESS     = 3'd1;
   localparam logic [2:0] F_LEQUAL   = 3'd2;
   localparam logic [2:0] F_GREATER  = 3'd3;
   localparam logic [2:0] F_GEQUAL   = 3'd4;
   localparam logic [2:0] F_EQUAL    = 3'd5;
   localparam logic [2:0] F_NOTEQUAL = 3'd6;
   localparam logic [2:0] F_ALWAYS   = 3'd7;

   // Stencil op encoding
   localparam logic [2:0] OP_KEEP      = 3'd0;
   localparam logic [2:0] OP_ZERO      = 3'd1;
   localparam logic [2:0] OP_REPLACE   = 3'd2;
   localparam logic [2:0] OP_INCR      = 3'd3;
   localparam logic [2:0] OP_DECR      = 3'd4;
   localparam logic [2:0] OP_INVERT    = 3'd5;
   localparam logic [2:0] OP_INCR_WRAP = 3'd6;
   localparam logic [2:0] OP_DECR_WRAP = 3'd7;

   localparam logic [AW-1:0] X_RES_A = AW'(X_RES);

   state_t            r_state;
   state_t            w_state_nxt;

   logic [AW-1:0]     r_addr;
   logic [ID_W-1:0]   r_id;
   logic [7:0]        r_ref;
   logic [2:0]        r_func;
   logic [7:0]        r_rmask;
   logic [7:0]        r_wmask;
   logic [2:0]        r_fail_op;
   logic [2:0]        r_pass_op;
   logic [7:0]        r_stored;
   logic [7:0]        r_new;
   logic              r_pass;

   logic              w_accept;
   logic              w_in_range;
   logic [AW-1:0]     w_addr;
   logic [7:0]        w_ref_m;
   logic [7:0]        w_sto_m;
   logic              w_pass;
   logic [2:0]        w_op;
   logic [7:0]        w_op_res;
   logic [7:0]        w_new;
   logic              w_take_rdata;

   logic              w_mem_req;
   logic              w_mem_we;
   logic              w_out_valid;
   logic              w_frag_ready;

   // Coordinates are widened to 32 bits so the range check stays correct
   // even when a resolution is an exact power of two.
   assign w_in_range = (32'(frag_x_i) < X_RES) && (32'(frag_y_i) < Y_RES);
   assign w_addr     = (AW'(frag_y_i) * X_RES_A) + AW'(frag_x_i);
   assign w_accept   = frag_valid_i && w_frag_ready;

   // Read data is captured in RD_WAIT, or already in the grant cycle when
   // the memory returns data with zero latency. Any other rvalid is stray.
   assign w_take_rdata = mem_rvalid_i &&
                         (((r_state == S_RD_REQ) && mem_gnt_i) || (r_state == S_RD_WAIT));

   // Masked compare of the latched reference against the stored word.
   always_comb begin
      w_ref_m = r_ref & r_rmask;
      w_sto_m = r_stored & r_rmask;
      w_pass  = 1'b0;
      case (r_func)
         F_NEVER:    w_pass = 1'b0;
         F_LESS:     w_pass = (w_ref_m <  w_sto_m);
         F_LEQUAL:   w_pass = (w_ref_m <= w_sto_m);
         F_GREATER:  w_pass = (w_ref_m >  w_sto_m);
         F_GEQUAL:   w_pass = (w_ref_m >= w_sto_m);
         F_EQUAL:    w_pass = (w_ref_m == w_sto_m);
         F_NOTEQUAL: w_pass = (w_ref_m != w_sto_m);
         F_ALWAYS:   w_pass = 1'b1;
         default:    w_pass = 1'b0;
      endcase
   end

   // Stencil op selected by the compare outcome, then merged through the
   // write mask so only the enabled bits of the stored word can change.
   always_comb begin
      w_op     = w_pass ? r_pass_op : r_fail_op;
      w_op_res = r_stored;
      case (w_op)
         OP_KEEP:      w_op_res = r_stored;
         OP_ZERO:      w_op_res = 8'h00;
         OP_REPLACE:   w_op_res = r_ref;
         OP_INCR:      w_op_res = (r_stored == 8'hFF) ? 8'hFF : (r_stored + 8'd1);
         OP_DECR:      w_op_res = (r_stored == 8'h00) ? 8'h00 : (r_stored - 8'd1);
         OP_INVERT:    w_op_res = ~r_stored;
         OP_INCR_WRAP: w_op_res = r_stored + 8'd1;
         OP_DECR_WRAP: w_op_res = r_stored - 8'd1;
         default:      w_op_res = r_stored;
      endcase
      w_new = (r_stored & ~r_wmask) | (w_op_res & r_wmask);
   end

   // State register. Reset drops any in-flight fragment immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs. Every stall simply holds the state,
   // so request and result outputs stay stable until their handshake.
   always_comb begin
      w_state_nxt  = r_state;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_out_valid  = 1'b0;
      w_frag_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_frag_ready = 1'b1;
            if (frag_valid_i) begin
               w_state_nxt = w_in_range ? S_RD_REQ : S_RESP;
            end
         end
         S_RD_REQ: begin
            w_mem_req = 1'b1;
            if (mem_gnt_i) begin
               w_state_nxt = mem_rvalid_i ? S_EVAL : S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (mem_rvalid_i) begin
               w_state_nxt = S_EVAL;
            end
         end
         S_EVAL: begin
            w_state_nxt = (w_new != r_stored) ? S_WR_REQ : S_RESP;
         end
         S_WR_REQ: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
            if (mem_gnt_i) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_out_valid = 1'b1;
            if (out_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Fragment and configuration latch at accept, read-data capture, and the
   // EVAL result registers. Out-of-range fragments report pass=0 directly.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr    <= '0;
         r_id      <= '0;
         r_ref     <= '0;
         r_func    <= '0;
         r_rmask   <= '0;
         r_wmask   <= '0;
         r_fail_op <= '0;
         r_pass_op <= '0;
         r_stored  <= '0;
         r_new     <= '0;
         r_pass    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr    <= w_addr;
            r_id      <= frag_id_i;
            r_ref     <= ref_val_i;
            r_func    <= func_i;
            r_rmask   <= read_mask_i;
            r_wmask   <= write_mask_i;
            r_fail_op <= fail_op_i;
            r_pass_op <= pass_op_i;
            r_pass    <= 1'b0;
         end
         if (w_take_rdata) begin
            r_stored <= mem_rdata_i;
         end
         if (r_state == S_EVAL) begin
            r_pass <= w_pass;
            r_new  <= w_new;
         end
      end
   end

   assign frag_ready_o = w_frag_ready;
   assign mem_req_o    = w_mem_req;
   assign mem_we_o     = w_mem_we;
   assign mem_addr_o   = r_addr;
   assign mem_wdata_o  = r_new;
   assign out_valid_o  = w_out_valid;
   assign out_id_o     = r_id;
   assign out_pass_o   = r_pass;
   assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_stencil_test_ctrl.sv
`timescale 1ns/1ps
// Testbench for stencil_test_ctrl. A stimulus process issues fragments and
// pushes expected reads, writes and results into queues; a memory responder
// and a result monitor pop and compare as the DUT presents transactions.
module tb_stencil_test_ctrl;

   localparam int X_RES = 1280;
   localparam int Y_RES = 720;
   localparam int ID_W  = 8;
   localparam int XW    = $clog2(X_RES);
   localparam int YW    = $clog2(Y_RES);
   localparam int AW    = $clog2(X_RES * Y_RES);

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            frag_valid_i;
   logic            frag_ready_o;
   logic [XW-1:0]   frag_x_i;
   logic [YW-1:0]   frag_y_i;
   logic [ID_W-1:0] frag_id_i;
   logic [7:0]      ref_val_i;
   logic [2:0]      func_i;
   logic [7:0]      read_mask_i;
   logic [7:0]      write_mask_i;
   logic [2:0]      fail_op_i;
   logic [2:0]      pass_op_i;
   logic            mem_req_o;
   logic            mem_gnt_i;
   logic            mem_we_o;
   logic [AW-1:0]   mem_addr_o;
   logic [7:0]      mem_wdata_o;
   logic            mem_rvalid_i;
   logic [7:0]      mem_rdata_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [ID_W-1:0] out_id_o;
   logic            out_pass_o;
   logic            busy_o;

   stencil_test_ctrl #(.X_RES(X_RES), .Y_RES(Y_RES), .ID_W(ID_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
      .frag_x_i(frag_x_i), .frag_y_i(frag_y_i), .frag_id_i(frag_id_i),
      .ref_val_i(ref_val_i), .func_i(func_i),
      .read_mask_i(read_mask_i), .write_mask_i(write_mask_i),
      .fail_op_i(fail_op_i), .pass_op_i(pass_op_i),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_id_o(out_id_o), .out_pass_o(out_pass_o), .busy_o(busy_o)
   );

   typedef struct { logic [7:0] id; logic pass; int lat; } resExp_t;
   typedef struct { int addr; logic [7:0] data; } wrExp_t;

   resExp_t    resQ[$];
   wrExp_t     writeQ[$];
   int         readQ[$];
   logic [7:0] memArr [int];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acceptCyc = 0;
   int respCount = 0;

   // Responder / monitor controls
   bit memRandom   = 1'b0;
   bit readyRandom = 1'b0;
   bit blockWrites = 1'b0;
   bit injectRvalid = 1'b0;
   int gntHold   = 0;
   int readyHold = 0;

   initial forever #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: event did not occur, expected it to (cycle %0d)", name, cyc);
   endtask

   // Reference model: stencil rules written as plain integer arithmetic.
   function automatic logic refPass(input logic [2:0] f, input logic [7:0] r,
                                    input logic [7:0] s, input logic [7:0] m);
      int a;
      int b;
      a = int'(r & m);
      b = int'(s & m);
      case (f)
         3'd0: return 1'b0;
         3'd1: return a <  b;
         3'd2: return a <= b;
         3'd3: return a >  b;
         3'd4: return a >= b;
         3'd5: return a == b;
         3'd6: return a != b;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [7:0] opResult(input logic [2:0] op, input logic [7:0] s, input logic [7:0] r);
      int v;
      v = int'(s);
      case (op)
         3'd0: return s;
         3'd1: return 8'd0;
         3'd2: return r;
         3'd3: return (v >= 255) ? 8'd255 : 8'(v + 1);
         3'd4: return (v <= 0) ? 8'd0 : 8'(v - 1);
         3'd5: return 8'(255 - v);
         3'd6: return 8'((v + 1) % 256);
         default: return 8'((v + 255) % 256);
      endcase
   endfunction

   task automatic scrambleInputs();
      frag_x_i     = XW'($urandom);
      frag_y_i     = YW'($urandom);
      frag_id_i    = ID_W'($urandom);
      ref_val_i    = 8'($urandom);
      func_i       = 3'($urandom);
      read_mask_i  = 8'($urandom);
      write_mask_i = 8'($urandom);
      fail_op_i    = 3'($urandom);
      pass_op_i    = 3'($urandom);
   endtask

   // Issues one fragment, records every expected memory and result event,
   // then waits (bounded) for the result to be reported.
   task automatic applyStimulus(input int x, input int y, input logic [7:0] id,
                                input logic [7:0] refv, input logic [2:0] func,
                                input logic [7:0] rm, input logic [7:0] wm,
                                input logic [2:0] fop, input logic [2:0] pop,
                                input logic [7:0] stored, input int expLat);
      int addr;
      int n;
      int start;
      logic p;
      logic [7:0] nv;
      resExp_t re;
      wrExp_t we;
      p = 1'b0;
      if (x < X_RES && y < Y_RES) begin
         addr = y * X_RES + x;
         memArr[addr] = stored;
         readQ.push_back(addr);
         p  = refPass(func, refv, stored, rm);
         nv = (stored & ~wm) | (opResult(p ? pop : fop, stored, refv) & wm);
         if (nv != stored) begin
            we.addr = addr;
            we.data = nv;
            writeQ.push_back(we);
         end
      end
      re.id = id; re.pass = p; re.lat = expLat;
      resQ.push_back(re);
      start = respCount;
      @(negedge clk_i);
      frag_x_i = XW'(x); frag_y_i = YW'(y); frag_id_i = id;
      ref_val_i = refv; func_i = func; read_mask_i = rm; write_mask_i = wm;
      fail_op_i = fop; pass_op_i = pop;
      frag_valid_i = 1'b1;
      n = 0;
      while (!frag_ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (!frag_ready_o) begin
         failNow("frag_accept");
         frag_valid_i = 1'b0;
         return;
      end
      acceptCyc = cyc;
      @(negedge clk_i);
      frag_valid_i = 1'b0;
      scrambleInputs();
      n = 0;
      while (respCount == start && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      if (respCount == start) failNow("result_timeout");
   endtask

   // Memory responder: grants requests (with optional stalls), returns read
   // data, checks every request against the expected read/write queues.
   initial begin
      bit rdPending;
      int rdDelay;
      logic [7:0] rdData;
      bit prevStall;
      logic [AW-1:0] pAddr;
      logic pWe;
      logic [7:0] pWdata;
      bit g;
      int a;
      wrExp_t w;
      rdPending = 0; rdDelay = 0; rdData = 0; prevStall = 0;
      pAddr = 0; pWe = 0; pWdata = 0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 8'h00;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            rdPending = 0; prevStall = 0;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            continue;
         end
         mem_rvalid_i = 1'b0;
         if (injectRvalid) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 8'h77;
            injectRvalid = 1'b0;
         end else if (rdPending) begin
            if (rdDelay == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = rdData;
               rdPending = 0;
            end else begin
               rdDelay--;
            end
         end
         if (prevStall) begin
            checkOutput("req_held", mem_req_o, 1);
            checkOutput("addr_held", mem_addr_o, pAddr);
            checkOutput("we_held", mem_we_o, pWe);
            if (pWe) checkOutput("wdata_held", mem_wdata_o, pWdata);
         end
         if (mem_req_o) begin
            g = 1'b1;
            if (gntHold > 0) begin
               g = 1'b0;
               gntHold--;
            end else if (mem_we_o && blockWrites) begin
               g = 1'b0;
            end else if (memRandom && $urandom_range(0, 2) == 0) begin
               g = 1'b0;
            end
            mem_gnt_i = g;
            if (g) begin
               a = int'(mem_addr_o);
               if (mem_we_o) begin
                  if (writeQ.size() == 0) begin
                     failNow("unexpected_write_absent");
                  end else begin
                     w = writeQ.pop_front();
                     checkOutput("write_addr", mem_addr_o, w.addr);
                     checkOutput("write_data", mem_wdata_o, w.data);
                  end
                  memArr[a] = mem_wdata_o;
               end else begin
                  if (readQ.size() == 0) begin
                     failNow("unexpected_read_absent");
                  end else begin
                     checkOutput("read_addr", mem_addr_o, readQ.pop_front());
                  end
                  rdData = memArr.exists(a) ? memArr[a] : 8'h00;
                  if (memRandom && $urandom_range(0, 3) == 0) begin
                     mem_rvalid_i = 1'b1;
                     mem_rdata_i  = rdData;
                  end else begin
                     rdPending = 1;
                     rdDelay   = memRandom ? $urandom_range(0, 2) : 0;
                  end
               end
            end
            prevStall = !g;
            pAddr = mem_addr_o; pWe = mem_we_o; pWdata = mem_wdata_o;
         end else begin
            mem_gnt_i = 1'b0;
            prevStall = 0;
         end
      end
   end

   // Result monitor: pops the expected result on each handshake and checks
   // that a stalled result stays valid and stable.
   initial begin
      bit waiting;
      int firstCyc;
      logic [7:0] hId;
      logic hPass;
      bit r;
      resExp_t e;
      waiting = 0; firstCyc = 0; hId = 0; hPass = 0;
      out_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            waiting = 0;
            out_ready_i = 1'b0;
            continue;
         end
         if (waiting) begin
            checkOutput("valid_held", out_valid_o, 1);
            checkOutput("id_held", out_id_o, hId);
            checkOutput("pass_held", out_pass_o, hPass);
         end
         if (out_valid_o) begin
            if (!waiting) firstCyc = cyc;
            if (readyHold > 0) begin
               r = 1'b0;
               readyHold--;
            end else begin
               r = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            out_ready_i = r;
            if (r) begin
               waiting = 0;
               if (resQ.size() == 0) begin
                  failNow("unexpected_result_absent");
               end else begin
                  e = resQ.pop_front();
                  checkOutput("out_id", out_id_o, e.id);
                  checkOutput("out_pass", out_pass_o, e.pass);
                  if (e.lat >= 0) checkOutput("latency", firstCyc - acceptCyc, e.lat);
               end
               respCount++;
            end else begin
               waiting = 1;
               hId = out_id_o;
               hPass = out_pass_o;
            end
         end else begin
            waiting = 0;
            out_ready_i = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #1_000_000;
      failNow("global_watchdog");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int x;
      int y;
      logic [7:0] rv;
      logic [7:0] st;
      rst_ni = 1'b0;
      frag_valid_i = 1'b0;
      scrambleInputs();
      repeat (3) @(negedge clk_i);
      checkOutput("rst_frag_ready", frag_ready_o, 1);
      checkOutput("rst_mem_req", mem_req_o, 0);
      checkOutput("rst_mem_we", mem_we_o, 0);
      checkOutput("rst_mem_addr", mem_addr_o, 0);
      checkOutput("rst_mem_wdata", mem_wdata_o, 0);
      checkOutput("rst_out_valid", out_valid_o, 0);
      checkOutput("rst_out_id", out_id_o, 0);
      checkOutput("rst_out_pass", out_pass_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Equal compare, REPLACE leaves value unchanged: pass, no write, 4 cycles
      applyStimulus(5, 3, 8'h11, 8'h05, 3'd5, 8'hFF, 8'hFF, 3'd0, 3'd2, 8'h05, 4);
      // LESS fails (7 < 3 false), INCR writes 0x04, 5 cycles
      applyStimulus(100, 2, 8'h12, 8'h07, 3'd1, 8'hFF, 8'hFF, 3'd3, 3'd0, 8'h03, 5);
      // Saturating vs wrapping increment/decrement at the rails
      applyStimulus(7, 7, 8'h13, 8'h00, 3'd7, 8'hFF, 8'hFF, 3'd0, 3'd3, 8'hFF, 4);
      applyStimulus(7, 7, 8'h14, 8'h00, 3'd7, 8'hFF, 8'hFF, 3'd0, 3'd6, 8'hFF, 5);
      applyStimulus(8, 7, 8'h15, 8'h00, 3'd7, 8'hFF, 8'hFF, 3'd0, 3'd4, 8'h00, 4);
      applyStimulus(8, 7, 8'h16, 8'h00, 3'd7, 8'hFF, 8'hFF, 3'd0, 3'd7, 8'h00, 5);
      // INVERT through write mask 0x0F: 0xA5 -> 0xAA
      applyStimulus(1279, 719, 8'h17, 8'h00, 3'd7, 8'hFF, 8'h0F, 3'd0, 3'd5, 8'hA5, 5);
      // Out-of-range x and y: no memory access, pass=0, result next cycle
      applyStimulus(1280, 0, 8'h18, 8'h00, 3'd7, 8'hFF, 8'hFF, 3'd1, 3'd1, 8'h00, 1);
      applyStimulus(0, 720, 8'h19, 8'h00, 3'd7, 8'hFF, 8'hFF, 3'd1, 3'd1, 8'h00, 1);
      // Grant held off 5 cycles, result ready held off 3 cycles
      gntHold = 5;
      readyHold = 3;
      applyStimulus(10, 20, 8'h1A, 8'h10, 3'd5, 8'hFF, 8'hFF, 3'd0, 3'd0, 8'h10, 9);

      // Reset while a write is pending: request drops, nothing is reported
      blockWrites = 1'b1;
      memArr[200 * X_RES + 100] = 8'h03;
      readQ.push_back(200 * X_RES + 100);
      @(negedge clk_i);
      frag_x_i = XW'(100); frag_y_i = YW'(200); frag_id_i = 8'h1B;
      ref_val_i = 8'h07; func_i = 3'd1; read_mask_i = 8'hFF; write_mask_i = 8'hFF;
      fail_op_i = 3'd3; pass_op_i = 3'd0;
      frag_valid_i = 1'b1;
      @(negedge clk_i);
      frag_valid_i = 1'b0;
      n = 0;
      while (!(mem_req_o && mem_we_o) && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput("reached_wr_req", {31'd0, mem_req_o && mem_we_o}, 1);
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("midrst_mem_req", mem_req_o, 0);
      checkOutput("midrst_out_valid", out_valid_o, 0);
      checkOutput("midrst_busy", busy_o, 0);
      checkOutput("midrst_frag_ready", frag_ready_o, 1);
      checkOutput("midrst_mem_addr", mem_addr_o, 0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      blockWrites = 1'b0;
      injectRvalid = 1'b1;
      repeat (3) @(negedge clk_i);
      checkOutput("late_rvalid_busy", busy_o, 0);
      checkOutput("late_rvalid_valid", out_valid_o, 0);
      checkOutput("late_rvalid_ready", frag_ready_o, 1);
      applyStimulus(100, 200, 8'h1C, 8'h07, 3'd1, 8'hFF, 8'hFF, 3'd3, 3'd0, 8'h03, 5);

      // Randomized fragments with random memory and result stalls
      memRandom = 1'b1;
      readyRandom = 1'b1;
      for (int i = 0; i < 40; i++) begin
         x  = ($urandom_range(0, 9) == 0) ? $urandom_range(X_RES, 2047) : $urandom_range(0, X_RES - 1);
         y  = ($urandom_range(0, 9) == 0) ? $urandom_range(Y_RES, 1023) : $urandom_range(0, Y_RES - 1);
         rv = 8'($urandom);
         st = ($urandom_range(0, 3) == 0) ? rv : 8'($urandom);
         applyStimulus(x, y, 8'(i + 32), rv, 3'($urandom), 8'($urandom), 8'($urandom),
                       3'($urandom), 3'($urandom), st, -1);
      end
      memRandom = 1'b0;
      readyRandom = 1'b0;
      repeat (5) @(negedge clk_i);

      checkOutput("results_drained", resQ.size(), 0);
      checkOutput("writes_drained", writeQ.size(), 0);
      checkOutput("reads_drained", readQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
